shift_deser: RTL and testbench

//   Serial-to-parallel receiver; the far end of the parallel-load shift register.
//   - Collects WIDTH serial bits, MSB-first or LSB-first, into one parallel word.
//   - Presents each word on a single-entry valid/ready output buffer.
//   - Sits between a serial link and a parallel consumer; reports dropped words via a sticky flag.

---
 rtl/shift_pkg.sv | 8 +
 rtl/shift_deser_obuf.sv | 52 +++++
 rtl/shift_deser.sv | 94 +++++++++
 tb/tb_shift_deser.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
package shift_pkg;

    typedef enum logic {ST_IDLE, ST_SHIFT} shift_st_t;

    localparam logic SHIFT_MSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deser_obuf.sv
// Single-entry valid/ready holding register; a word arriving while the held
// word is still unconsumed is dropped and flagged in a sticky overflow bit.
module shift_deser_obuf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_data,
    input  logic             par_rdy,
    output logic [WIDTH-1:0] par_out,
    output logic             par_vld,
    output logic             overflow
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        out_d = out_q;
        vld_d = vld_q;
        ovf_d = ovf_q;
        if (load_vld) begin
            if (!vld_q || par_rdy) begin
                out_d = load_data;
                vld_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (vld_q && par_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
            ovf_q <= ovf_d;
        end
    end

    assign par_out  = out_q;
    assign par_vld  = vld_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: shifter, bit counter and shift FSM, feeding
// a single-entry output buffer.
//   state    | meaning
//   ST_IDLE  | bit_cnt == 0, no partial word held
//   ST_SHIFT | 0 < bit_cnt < WIDTH, partial word in progress
module shift_deser
    import shift_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sdata_in,
    input  logic             sdata_vld,
    input  logic             msb_first,
    input  logic             frame_start,
    output logic [WIDTH-1:0] par_out,
    output logic             par_vld,
    input  logic             par_rdy,
    output logic             busy,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             dir_q, dir_d;
    shift_st_t        st_q, st_d;

    logic             first_bit;
    logic             dir_eff;
    logic [WIDTH-1:0] sh_base;
    logic [CNT_W-1:0] cnt_base;
    logic             word_done;

    always_comb begin
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        dir_d     = dir_q;
        word_done = 1'b0;
        first_bit = frame_start || (bit_cnt_q == '0);
        dir_eff   = first_bit ? msb_first : dir_q;
        // frame_start restarts the word, so the stale partial is not shifted on
        sh_base   = frame_start ? '0 : sh_q;
        cnt_base  = frame_start ? '0 : bit_cnt_q;
        if (sdata_vld) begin
            dir_d = dir_eff;
            if (dir_eff == SHIFT_MSB_FIRST) begin
                sh_d = {sh_base[WIDTH-2:0], sdata_in};
            end else begin
                sh_d = {sdata_in, sh_base[WIDTH-1:1]};
            end
            if (cnt_base == LAST_CNT) begin
                bit_cnt_d = '0;
                word_done = 1'b1;
            end else begin
                bit_cnt_d = cnt_base + CNT_W'(1);
            end
        end else if (frame_start) begin
            bit_cnt_d = '0;
        end
        st_d = (bit_cnt_d == '0) ? ST_IDLE : ST_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q      <= '0;
            bit_cnt_q <= '0;
            dir_q     <= 1'b0;
            st_q      <= ST_IDLE;
        end else begin
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            dir_q     <= dir_d;
            st_q      <= st_d;
        end
    end

    assign busy = (st_q == ST_SHIFT);

    shift_deser_obuf #(.WIDTH(WIDTH)) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .load_vld  (word_done),
        .load_data (sh_d),
        .par_rdy   (par_rdy),
        .par_out   (par_out),
        .par_vld   (par_vld),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_shift_deser.sv
// Directed and random bench for shift_deser against a bit-list reference model.
module tb_shift_deser;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, sdata_in, sdata_vld, msb_first, frame_start, par_rdy;
    logic [W-1:0] par_out;
    logic         par_vld, busy, overflow;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic         m_bits[$];
    logic         m_dir;
    logic [W-1:0] m_out;
    logic         m_vld;
    logic         m_ovf;

    always #5 clk = ~clk;

    shift_deser #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sdata_in    (sdata_in),
        .sdata_vld   (sdata_vld),
        .msb_first   (msb_first),
        .frame_start (frame_start),
        .par_out     (par_out),
        .par_vld     (par_vld),
        .par_rdy     (par_rdy),
        .busy        (busy),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] assemble(input logic dir);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (dir) w[W-1-i] = m_bits[i];
            else     w[i]     = m_bits[i];
        end
        return w;
    endfunction

    task automatic model_edge();
        logic         done;
        logic [W-1:0] word;
        done = 1'b0;
        word = '0;
        if (rst) begin
            m_bits.delete();
            m_dir = 1'b0;
            m_out = '0;
            m_vld = 1'b0;
            m_ovf = 1'b0;
        end else begin
            if (frame_start) m_bits.delete();
            if (sdata_vld) begin
                if (m_bits.size() == 0) m_dir = msb_first;
                m_bits.push_back(sdata_in);
                if (m_bits.size() == W) begin
                    word = assemble(m_dir);
                    done = 1'b1;
                    m_bits.delete();
                end
            end
            if (done) begin
                if (!m_vld || par_rdy) begin
                    m_out = word;
                    m_vld = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_vld && par_rdy) begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic b,
                        input logic m, input logic f, input logic y);
        rst = r; sdata_vld = v; sdata_in = b; msb_first = m; frame_start = f; par_rdy = y;
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".par_out"},  32'(par_out),  32'(m_out));
        chk({tag, ".par_vld"},  32'(par_vld),  32'(m_vld));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".busy"},     32'(busy),     32'(m_bits.size() != 0));
    endtask

    task automatic send(input string tag, input logic [W-1:0] bits, input logic m, input logic y);
        for (int i = W - 1; i >= 0; i--) step(tag, 1'b0, 1'b1, bits[i], m, 1'b0, y);
    endtask

    initial begin
        m_dir = 1'b0; m_out = '0; m_vld = 1'b0; m_ovf = 1'b0;

        // reset
        step("rst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_par_out", 32'(par_out), 32'h0);
        chk("rst_par_vld", 32'(par_vld), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // 1: MSB-first 1011, one-cycle valid
        send("t1", 4'b1011, 1'b1, 1'b1);
        chk("t1_word", 32'(par_out), 32'hB);
        chk("t1_vld", 32'(par_vld), 32'h1);
        step("t1_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t1_vld_drop", 32'(par_vld), 32'h0);

        // 2: LSB-first, msb_first toggled after the first bit
        step("t2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step("t2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step("t2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("t2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_word", 32'(par_out), 32'hD);
        step("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 3: consumer stalled, second word dropped
        send("t3a", 4'b1011, 1'b1, 1'b0);
        send("t3b", 4'b0110, 1'b1, 1'b0);
        chk("t3_held", 32'(par_out), 32'hB);
        chk("t3_ovf", 32'(overflow), 32'h1);
        step("t3_rdy", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t3_vld_fall", 32'(par_vld), 32'h0);
        chk("t3_ovf_sticky", 32'(overflow), 32'h1);

        // 4: load and consume on the same edge
        step("t4_rst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send("t4a", 4'b1001, 1'b1, 1'b0);
        step("t4b", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t4b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("t4b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("t4b", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_word", 32'(par_out), 32'h6);
        chk("t4_vld", 32'(par_vld), 32'h1);
        chk("t4_ovf", 32'(overflow), 32'h0);
        step("t4_drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // 5: frame_start with a bit restarts the word
        step("t5", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("t5", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("t5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step("t5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step("t5", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_busy_mid", 32'(busy), 32'h1);
        step("t5", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_word", 32'(par_out), 32'h3);
        chk("t5_busy", 32'(busy), 32'h0);

        // 6: reset mid-word
        step("t6", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("t6", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step("t6", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("t6_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t6_rst_out", 32'({par_out, par_vld, busy, overflow}), 32'h0);
        send("t6", 4'b1110, 1'b1, 1'b1);
        chk("t6_word", 32'(par_out), 32'hE);
        chk("t6_ovf", 32'(overflow), 32'h0);

        // frame_start alone discards a partial word
        step("fs", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("fs", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("fs_busy", 32'(busy), 32'h0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step("rnd", ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
